rf_param_sb: RTL and testbench
==============================

Name: rf_param_sb

Overview:
- Parametrised successor to the 8x8 register file used by the RISC-V datapath.
- Configurable data width and register count.
- Two combinational read ports and one clocked write port.
- Optional hardwired-zero r0 and optional write-to-read bypass.
- A per-register pending scoreboard, so the control FSM can stall on registers whose producer (e.g. a multi-cycle load) has not yet written back.

Parameters:
- DATA_W, 8, register data width in bits.
- NREGS, 8, number of registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width; derived, not overridden.
- ZERO_R0, 1, 1 = r0 reads 0, and writes and marks to r0 are ignored.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- RFWrite  in  1  write enable for the writeback port.
- regW  in  AW  write address.
- dataW  in  DATA_W  write data.
- regA  in  AW  read port A address.
- regB  in  AW  read port B address.
- dataA  out  DATA_W  read port A data (combinational).
- dataB  out  DATA_W  read port B data (combinational).
- markPend  in  1  set the pending bit of regM (producer issued).
- regM  in  AW  register to mark pending.
- hazardA  out  1  regA has an unresolved producer.
- hazardB  out  1  regB has an unresolved producer.
- pendCount  out  AW+1  number of pending registers.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers and all pending bits clear to 0 immediately.
  - dataA, dataB, hazardA, hazardB and pendCount read 0 while reset is low.
  - Writes and marks are ignored while reset is low.
  - First functional edge is the first rising clock with reset=1.
- Write:
  - On a rising edge with RFWrite=1, registers[regW] <= dataW and pending[regW] <= 0.
  - Exception: when ZERO_R0=1 and regW=0, nothing changes.
  - Write latency is 1 cycle.
- Mark:
  - On a rising edge with markPend=1, pending[regM] <= 1.
  - Ignored when ZERO_R0=1 and regM=0.
- Simultaneous write and mark, same register: mark wins (pending=1, data still updated). This models a new in-flight producer superseding the completing one.
- Simultaneous write and mark, different registers: both take effect.
- Read port A (port B is identical with regB/dataB/hazardB):
  - When ZERO_R0=1 and regA=0: dataA=0, hazardA=0.
  - Otherwise, when BYPASS=1 and RFWrite=1 and regW=regA and the write is not to a suppressed r0: dataA=dataW, hazardA=0.
  - Otherwise: dataA=registers[regA], hazardA=pending[regA].
- Bypass disabled (BYPASS=0): reads return the pre-edge register value; new data is visible the cycle after the write.
- pendCount: registered population count of the pending bits, updated on the same edge as the bits, so it equals the popcount of the current pending vector. Range is 0..NREGS; the AW+1 width holds NREGS.
- Addresses are always in range (NREGS is a power of two), so there is no out-of-range case.
- Reset mid-operation: pending bits and data clear together; no partial state survives.

Decomposition:
- Package rf_pkg holds:
  - localparam helper for AW.
  - Popcount function.
  - Typedef of the register index.
- Sub-module rf_read_port, instantiated twice. It contains the r0/bypass/array mux and the hazard logic for one read port.
- Storage, pending vector and count stay in the top level.

Test Plan:
- Reset: hold reset=0 with RFWrite=1, regW=3, dataW=8'hAA. Expect dataA(regA=3)=0 and pendCount=0. Release reset; the first edge then writes 8'hAA and dataA=8'hAA.
- Write/read and bypass: with BYPASS=1, drive RFWrite=1, regW=5, dataW=8'h5C, regA=5. Expect dataA=8'h5C in the same cycle before the edge. With BYPASS=0, expect dataA=8'h5C only after the edge.
- r0 handling: with ZERO_R0=1, write 8'hFF to r0 and mark r0. Expect dataB(regB=0)=0, hazardB=0, pendCount=0.
- Scoreboard: mark r2 -> hazardA(regA=2)=1, pendCount=1. Write r2=8'h11 -> next cycle hazardA=0, pendCount=0. During the write cycle, expect hazardA=0 via bypass.
- Simultaneous events:
  - Write and mark r4 on the same edge -> pending[4]=1, data=new value.
  - Mark r1 while writing r6 -> pendCount increases by 1.
- Parametrisation: DATA_W=32, NREGS=32. Fill all registers with their index. Read every pair (i, 31-i). Mark all 31 non-zero registers -> pendCount=31.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file with scoreboard:
// address-width helper, register index type and a population-count function.
package rf_pkg;

    // Largest register count the popcount helper covers.
    localparam int RF_MAX_REGS = 256;

    // Register index wide enough for the largest supported register count.
    typedef logic [7:0] rf_idx_t;

    // Pending-count type wide enough to hold RF_MAX_REGS.
    typedef logic [8:0] rf_cnt_t;

    // Address width for a register file of nregs entries (at least 1 bit).
    function automatic int rf_aw(input int nregs);
        return (nregs < 2) ? 1 : $clog2(nregs);
    endfunction

    // Number of set bits in a (zero-extended) pending vector.
    function automatic rf_cnt_t rf_popcount(input logic [RF_MAX_REGS-1:0] bits);
        rf_cnt_t cnt;
        cnt = '0;
        for (int i = 0; i < RF_MAX_REGS; i++) begin
            cnt = cnt + rf_cnt_t'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rf_param_sb_read_port.sv
// One combinational read port: hardwired-zero r0, same-cycle write bypass,
// storage mux and the matching hazard flag.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 8,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
)(
    input  logic                           active,
    input  logic [NREGS-1:0][DATA_W-1:0]   regs,
    input  logic [NREGS-1:0]               pending,
    input  logic                           wen,
    input  logic [AW-1:0]                  waddr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [AW-1:0]                  raddr,
    output logic [DATA_W-1:0]              rdata,
    output logic                           hazard
);

    // Priority: reset forces zero, then r0, then bypass, then storage.
    // A forwarded write is by definition the resolving producer, so no hazard.
    always_comb begin
        rdata  = '0;
        hazard = 1'b0;
        if (!active) begin
            rdata  = '0;
            hazard = 1'b0;
        end else if ((ZERO_R0 != 0) && (raddr == '0)) begin
            rdata  = '0;
            hazard = 1'b0;
        end else if ((BYPASS != 0) && wen && (waddr == raddr)) begin
            rdata  = wdata;
            hazard = 1'b0;
        end else begin
            rdata  = regs[raddr];
            hazard = pending[raddr];
        end
    end

endmodule

// File: rtl/rf_param_sb.sv
// Parametrised register file with two combinational read ports, one clocked
// write port and a per-register pending scoreboard for producer stalls.
module rf_param_sb
    import rf_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 8,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = rf_aw(NREGS)
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              RFWrite,
    input  logic [AW-1:0]     regW,
    input  logic [DATA_W-1:0] dataW,
    input  logic [AW-1:0]     regA,
    input  logic [AW-1:0]     regB,
    output logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] dataB,
    input  logic              markPend,
    input  logic [AW-1:0]     regM,
    output logic              hazardA,
    output logic              hazardB,
    output logic [AW:0]       pendCount
);

    logic [NREGS-1:0][DATA_W-1:0] regs_reg;
    logic [NREGS-1:0][DATA_W-1:0] regs_next;
    logic [NREGS-1:0]             pending_reg;
    logic [NREGS-1:0]             pending_next;
    logic [AW:0]                  pend_cnt_reg;
    logic [AW:0]                  pend_cnt_next;
    logic                         wr_eff;
    logic                         mk_eff;

    // Writes and marks aimed at a hardwired-zero r0 are dropped entirely.
    assign wr_eff = RFWrite  && !((ZERO_R0 != 0) && (regW == '0));
    assign mk_eff = markPend && !((ZERO_R0 != 0) && (regM == '0));

    // Per-register next state; a mark overrides a completing write on the
    // same register because it represents a newer in-flight producer.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            assign regs_next[gi] = (wr_eff && (regW == AW'(gi))) ? dataW : regs_reg[gi];
            assign pending_next[gi] = (mk_eff && (regM == AW'(gi))) ? 1'b1 :
                                      (wr_eff && (regW == AW'(gi))) ? 1'b0 :
                                      pending_reg[gi];
        end
    endgenerate

    // Count tracks the vector being loaded so it always matches the bits.
    assign pend_cnt_next = (AW+1)'(rf_popcount(RF_MAX_REGS'(pending_next)));

    // Storage, scoreboard and count share one asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs_reg     <= '0;
            pending_reg  <= '0;
            pend_cnt_reg <= '0;
        end else begin
            regs_reg     <= regs_next;
            pending_reg  <= pending_next;
            pend_cnt_reg <= pend_cnt_next;
        end
    end

    assign pendCount = pend_cnt_reg;

    rf_read_port #(
        .DATA_W  (DATA_W),
        .NREGS   (NREGS),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0),
        .BYPASS  (BYPASS)
    ) u_port_a (
        .active  (reset),
        .regs    (regs_reg),
        .pending (pending_reg),
        .wen     (wr_eff),
        .waddr   (regW),
        .wdata   (dataW),
        .raddr   (regA),
        .rdata   (dataA),
        .hazard  (hazardA)
    );

    rf_read_port #(
        .DATA_W  (DATA_W),
        .NREGS   (NREGS),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0),
        .BYPASS  (BYPASS)
    ) u_port_b (
        .active  (reset),
        .regs    (regs_reg),
        .pending (pending_reg),
        .wen     (wr_eff),
        .waddr   (regW),
        .wdata   (dataW),
        .raddr   (regB),
        .rdata   (dataB),
        .hazard  (hazardB)
    );

endmodule

// File: tb/tb_rf_param_sb.sv
// Directed bench for rf_param_sb: default 8x8 with bypass, an 8x8 copy
// without bypass, and a 32x32 copy for the wide/deep configuration.
module tb_rf_param_sb;

    logic clock;
    logic rst_n;

    // Instance a: DATA_W=8, NREGS=8, ZERO_R0=1, BYPASS=1
    logic       a_wr, a_mk, a_hzA, a_hzB;
    logic [2:0] a_regW, a_regA, a_regB, a_regM;
    logic [7:0] a_dataW, a_dataA, a_dataB;
    logic [3:0] a_cnt;

    // Instance b: same, BYPASS=0
    logic       b_wr, b_mk, b_hzA, b_hzB;
    logic [2:0] b_regW, b_regA, b_regB, b_regM;
    logic [7:0] b_dataW, b_dataA, b_dataB;
    logic [3:0] b_cnt;

    // Instance w: DATA_W=32, NREGS=32
    logic        w_wr, w_mk, w_hzA, w_hzB;
    logic [4:0]  w_regW, w_regA, w_regB, w_regM;
    logic [31:0] w_dataW, w_dataA, w_dataB;
    logic [5:0]  w_cnt;

    int vectors;
    int miscompares;

    rf_param_sb u_a (
        .clock(clock), .reset(rst_n), .RFWrite(a_wr), .regW(a_regW), .dataW(a_dataW),
        .regA(a_regA), .regB(a_regB), .dataA(a_dataA), .dataB(a_dataB),
        .markPend(a_mk), .regM(a_regM), .hazardA(a_hzA), .hazardB(a_hzB), .pendCount(a_cnt)
    );

    rf_param_sb #(.BYPASS(0)) u_b (
        .clock(clock), .reset(rst_n), .RFWrite(b_wr), .regW(b_regW), .dataW(b_dataW),
        .regA(b_regA), .regB(b_regB), .dataA(b_dataA), .dataB(b_dataB),
        .markPend(b_mk), .regM(b_regM), .hazardA(b_hzA), .hazardB(b_hzB), .pendCount(b_cnt)
    );

    rf_param_sb #(.DATA_W(32), .NREGS(32)) u_w (
        .clock(clock), .reset(rst_n), .RFWrite(w_wr), .regW(w_regW), .dataW(w_dataW),
        .regA(w_regA), .regB(w_regB), .dataA(w_dataA), .dataB(w_dataB),
        .markPend(w_mk), .regM(w_regM), .hazardA(w_hzA), .hazardB(w_hzB), .pendCount(w_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Advance past the next rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a_wr = 0; a_mk = 0; a_regW = 0; a_regA = 0; a_regB = 0; a_regM = 0; a_dataW = 0;
        b_wr = 0; b_mk = 0; b_regW = 0; b_regA = 0; b_regB = 0; b_regM = 0; b_dataW = 0;
        w_wr = 0; w_mk = 0; w_regW = 0; w_regA = 0; w_regB = 0; w_regM = 0; w_dataW = 0;

        // Reset held with a write pending: everything reads zero.
        a_wr = 1; a_regW = 3; a_dataW = 8'hAA; a_regA = 3;
        tick();
        tick();
        check("rst_dataA", 32'(a_dataA), 32'h0);
        check("rst_cnt",   32'(a_cnt),   32'h0);
        check("rst_hzA",   32'(a_hzA),   32'h0);

        // Release mid-cycle; the next edge performs the write.
        @(negedge clock);
        rst_n = 1'b1;
        tick();
        a_wr = 0;
        #1;
        check("first_wr_dataA", 32'(a_dataA), 32'hAA);

        // Bypass vs no bypass on the same write.
        a_wr = 1; a_regW = 5; a_dataW = 8'h5C; a_regA = 5;
        b_wr = 1; b_regW = 5; b_dataW = 8'h5C; b_regA = 5;
        #1;
        check("byp_pre_a", 32'(a_dataA), 32'h5C);
        check("nobyp_pre_b", 32'(b_dataA), 32'h00);
        tick();
        a_wr = 0; b_wr = 0;
        #1;
        check("byp_post_a", 32'(a_dataA), 32'h5C);
        check("nobyp_post_b", 32'(b_dataA), 32'h5C);

        // r0 is hardwired: write and mark both dropped.
        a_wr = 1; a_regW = 0; a_dataW = 8'hFF; a_mk = 1; a_regM = 0; a_regB = 0;
        #1;
        check("r0_byp_dataB", 32'(a_dataB), 32'h0);
        tick();
        a_wr = 0; a_mk = 0;
        #1;
        check("r0_dataB", 32'(a_dataB), 32'h0);
        check("r0_hzB",   32'(a_hzB),   32'h0);
        check("r0_cnt",   32'(a_cnt),   32'h0);

        // Scoreboard: mark r2, then resolve it with a write.
        a_mk = 1; a_regM = 2;
        b_mk = 1; b_regM = 2;
        tick();
        a_mk = 0; b_mk = 0; a_regA = 2; b_regA = 2;
        #1;
        check("mark_hzA", 32'(a_hzA), 32'h1);
        check("mark_cnt", 32'(a_cnt), 32'h1);
        a_wr = 1; a_regW = 2; a_dataW = 8'h11;
        b_wr = 1; b_regW = 2; b_dataW = 8'h11;
        #1;
        check("wrcyc_hzA_byp",   32'(a_hzA),   32'h0);
        check("wrcyc_dataA_byp", 32'(a_dataA), 32'h11);
        check("wrcyc_hzA_nobyp", 32'(b_hzA),   32'h1);
        tick();
        a_wr = 0; b_wr = 0;
        #1;
        check("resolved_hzA",   32'(a_hzA),   32'h0);
        check("resolved_cnt",   32'(a_cnt),   32'h0);
        check("resolved_dataA", 32'(a_dataA), 32'h11);
        check("resolved_cnt_b", 32'(b_cnt),   32'h0);

        // Write and mark same register: mark wins, data still updates.
        a_wr = 1; a_regW = 4; a_dataW = 8'h44; a_mk = 1; a_regM = 4;
        tick();
        a_wr = 0; a_mk = 0; a_regA = 4;
        #1;
        check("same_dataA", 32'(a_dataA), 32'h44);
        check("same_hzA",   32'(a_hzA),   32'h1);
        check("same_cnt",   32'(a_cnt),   32'h1);

        // Mark r1 while writing r6: both take effect.
        a_wr = 1; a_regW = 6; a_dataW = 8'h66; a_mk = 1; a_regM = 1;
        tick();
        a_wr = 0; a_mk = 0; a_regA = 1; a_regB = 6;
        #1;
        check("diff_cnt",   32'(a_cnt),   32'h2);
        check("diff_hzA",   32'(a_hzA),   32'h1);
        check("diff_dataB", 32'(a_dataB), 32'h66);
        check("diff_hzB",   32'(a_hzB),   32'h0);

        // Wide configuration: fill every register with its index.
        for (int i = 0; i < 32; i++) begin
            w_wr = 1; w_regW = 5'(i); w_dataW = 32'(i);
            tick();
        end
        w_wr = 0;
        for (int i = 0; i < 32; i++) begin
            w_regA = 5'(i); w_regB = 5'(31 - i);
            #1;
            check($sformatf("w_A%0d", i), w_dataA, 32'(i));
            check($sformatf("w_B%0d", 31 - i), w_dataB, 32'(31 - i));
        end
        // Mark every register including r0 (which must be ignored).
        for (int i = 0; i < 32; i++) begin
            w_mk = 1; w_regM = 5'(i);
            tick();
        end
        w_mk = 0;
        w_regA = 5'd17; w_regB = 5'd0;
        #1;
        check("w_cnt_all", 32'(w_cnt), 32'd31);
        check("w_hzA17",   32'(w_hzA), 32'h1);
        check("w_hzB0",    32'(w_hzB), 32'h0);

        // Asynchronous reset mid-operation clears data, pending and count at once.
        rst_n = 1'b0;
        #1;
        check("midrst_a_cnt",   32'(a_cnt),   32'h0);
        check("midrst_a_dataB", 32'(a_dataB), 32'h0);
        check("midrst_w_cnt",   32'(w_cnt),   32'h0);
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        check("postrst_a_dataB", 32'(a_dataB), 32'h0);
        check("postrst_a_hzA",   32'(a_hzA),   32'h0);
        check("postrst_w_dataA", w_dataA,      32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
